apb_req_arbiter: RTL

- Fast-domain front end of the asynchronous APB bridge.
- Arbitrates up to NUM_REQ local requesters and owns the toggle-request handshake towards the low-frequency APB side: drives the a_apb_req toggle and holds the payload stable, then synchronises the returning b_ready_req toggle.
- Returns read data and a one-cycle completion pulse to the winning requester.
- Exactly one bridge transfer is outstanding at any time.

---
 rtl/apb_req_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: fast-domain front end of the asynchronous APB bridge.
// Arbitrates NUM_REQ requesters, drives the a_apb_req toggle with a stable
// payload, synchronises the returning b_ready_req toggle and pulses req_done.
// Optional: define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); default build is round-robin.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int STRB_WD = 4,
    parameter int PROT_WD = 3
) (
    input  logic                       a_pclk,
    input  logic                       a_prst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WD-1:0] req_wdata,
    input  logic [NUM_REQ*PROT_WD-1:0] req_prot,
    input  logic [NUM_REQ*STRB_WD-1:0] req_strb,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [DATA_WD-1:0]         req_rdata,
    output logic                       busy,
    output logic                       stray_ack,
    output logic                       a_apb_req,
    output logic                       write,
    output logic [ADDR_WD-1:0]         addr,
    output logic [DATA_WD-1:0]         wdata,
    output logic [PROT_WD-1:0]         prot,
    output logic [STRB_WD-1:0]         strb,
    input  logic                       b_ready_req,
    input  logic [DATA_WD-1:0]         rdata
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_s1, r_s2, r_s3;
    logic                 w_ready_edge;

    logic                 w_any;
    logic [GW-1:0]        w_gnt;
    logic [GW-1:0]        r_gnt;

    logic                 w_sel_write;
    logic [ADDR_WD-1:0]   w_sel_addr;
    logic [DATA_WD-1:0]   w_sel_wdata;
    logic [PROT_WD-1:0]   w_sel_prot;
    logic [STRB_WD-1:0]   w_sel_strb;

    logic                 r_req_tgl;
    logic                 r_write;
    logic [ADDR_WD-1:0]   r_addr;
    logic [DATA_WD-1:0]   r_wdata;
    logic [PROT_WD-1:0]   r_prot;
    logic [STRB_WD-1:0]   r_strb;
    logic [DATA_WD-1:0]   r_rdata;
    logic                 r_stray;

    assign w_any        = |req_valid;
    assign w_ready_edge = r_s2 ^ r_s3;

    assign a_apb_req = r_req_tgl;
    assign write     = r_write;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign prot      = r_prot;
    assign strb      = r_strb;
    assign req_rdata = r_rdata;
    assign stray_ack = r_stray;

    // Three-flop synchroniser for the slow-domain ready toggle; s2/s3 give the edge.
    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= b_ready_req;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef APB_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest valid index wins.
    always_comb begin
        w_gnt = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) w_gnt = GW'(j);
        end
    end
`else
    logic [GW-1:0] r_last_gnt;
    int            w_best_d;
    int            w_dist;

    // Round-robin: pick the valid requester closest after last_gnt (with wrap).
    always_comb begin
        w_gnt    = '0;
        w_best_d = NUM_REQ;
        w_dist   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(r_last_gnt)) % NUM_REQ;
            if (req_valid[j] && (w_dist < w_best_d)) begin
                w_best_d = w_dist;
                w_gnt    = GW'(j);
            end
        end
    end

    // Remember the requester served last; updated only when its transfer completes.
    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            r_last_gnt <= GW'(NUM_REQ - 1);
        end else if (r_state == ST_DONE) begin
            r_last_gnt <= r_gnt;
        end
    end
`endif

    // Select the winning requester's payload slices.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_prot  = '0;
        w_sel_strb  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt == GW'(j)) begin
                w_sel_write = req_write[j];
                w_sel_addr  = req_addr[j*ADDR_WD +: ADDR_WD];
                w_sel_wdata = req_wdata[j*DATA_WD +: DATA_WD];
                w_sel_prot  = req_prot[j*PROT_WD +: PROT_WD];
                w_sel_strb  = req_strb[j*STRB_WD +: STRB_WD];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next state plus Moore outputs (busy, one-hot done pulse).
    always_comb begin
        w_state_nxt = r_state;
        req_done    = '0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_any) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_ready_edge) w_state_nxt = ST_DONE;
            ST_DONE: begin
                req_done[r_gnt] = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload latch in IDLE, request toggle in ISSUE, read-data capture in WAIT.
    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            r_gnt     <= '0;
            r_req_tgl <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_prot    <= '0;
            r_strb    <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_write <= w_sel_write;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_prot  <= w_sel_prot;
                        r_strb  <= w_sel_strb;
                    end
                end
                ST_ISSUE: r_req_tgl <= ~r_req_tgl;
                ST_WAIT:  if (w_ready_edge) r_rdata <= rdata;
                default:  ;
            endcase
        end
    end

    // A ready edge outside WAIT means the bridges disagree; flag it until reset.
    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n)                                r_stray <= 1'b0;
        else if (w_ready_edge && r_state != ST_WAIT) r_stray <= 1'b1;
    end

endmodule
